// File: rtl/counter_updown_mod_nbit.sv
// Up/down counter with programmable modulus and step, wrap/saturate/one-shot modes.
// count, tc, busy and done are registered; at_max/at_min decode the count register.
module counter_updown_mod_nbit #(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load_en,
    input  logic [CNT_WIDTH-1:0]  load_val,
    input  logic                  en,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0]  limit,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  tc,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned EXT_W = CNT_WIDTH + 2;
    localparam logic [1:0]  MODE_SAT = 2'b01;
    localparam logic [1:0]  MODE_ONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   tc_q, tc_d;
    logic                   busy_q, done_q;

    logic [EXT_W-1:0]       cnt_x, lim_x, mod_x, s_x, s_mod_x;
    logic [EXT_W-1:0]       sum_x, diff_x, wrap_up_x, wrap_dn_x;
    logic                   over_c, under_c, oneshot_c;
    logic [CNT_WIDTH-1:0]   wrap_res_c, sat_res_c;

    // Widened step arithmetic; modulo folds steps larger than the range
    always_comb begin
        cnt_x     = EXT_W'(count_q);
        lim_x     = EXT_W'(limit);
        mod_x     = lim_x + EXT_W'(1);
        s_x       = (step == '0) ? EXT_W'(1) : EXT_W'(step);
        s_mod_x   = s_x % mod_x;
        sum_x     = cnt_x + s_x;
        diff_x    = cnt_x - s_x;
        over_c    = sum_x > lim_x;
        under_c   = cnt_x < s_x;
        wrap_up_x = sum_x % mod_x;
        wrap_dn_x = (cnt_x + mod_x - s_mod_x) % mod_x;

        if (up_down) begin
            wrap_res_c = over_c ? CNT_WIDTH'(wrap_up_x) : CNT_WIDTH'(sum_x);
            sat_res_c  = over_c ? limit : CNT_WIDTH'(sum_x);
        end else begin
            wrap_res_c = under_c ? CNT_WIDTH'(wrap_dn_x) : CNT_WIDTH'(diff_x);
            sat_res_c  = under_c ? '0 : CNT_WIDTH'(diff_x);
        end
    end

    assign oneshot_c = (mode == MODE_ONE);

    // Next-state: clr > load_en > start (one-shot) > en
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (clr) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (load_en) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (oneshot_c && start) begin
            count_d = up_down ? '0 : limit;
            state_d = ST_RUN;
        end else if (en) begin
            if (oneshot_c) begin
                if (state_q == ST_RUN) begin
                    count_d = sat_res_c;
                    tc_d    = up_down ? (sat_res_c == limit) : (sat_res_c == '0);
                    if (tc_d) begin
                        state_d = ST_DONE;
                    end
                end
            end else begin
                count_d = (mode == MODE_SAT) ? sat_res_c : wrap_res_c;
                tc_d    = up_down ? over_c : under_c;
            end
        end

        if (!oneshot_c) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign at_max = (count_q == limit);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_counter_updown_mod_nbit.sv
// Directed-vector bench for counter_updown_mod_nbit with hand-computed expectations.
module tb_counter_updown_mod_nbit;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       load_en;
    logic [7:0] load_val;
    logic       en;
    logic       up_down;
    logic [3:0] step;
    logic [7:0] limit;
    logic [1:0] mode;
    logic       start;
    logic [7:0] count;
    logic       tc;
    logic       at_max;
    logic       at_min;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    counter_updown_mod_nbit #(
        .CNT_WIDTH (8),
        .STEP_WIDTH(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .load_en (load_en),
        .load_val(load_val),
        .en      (en),
        .up_down (up_down),
        .step    (step),
        .limit   (limit),
        .mode    (mode),
        .start   (start),
        .count   (count),
        .tc      (tc),
        .at_max  (at_max),
        .at_min  (at_min),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        load_en  = 1'b1;
        load_val = v;
        en       = 1'b0;
        tick();
        load_en  = 1'b0;
    endtask

    int exp_wu_cnt[7] = '{3, 6, 9, 2, 5, 8, 1};
    int exp_wu_tc[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int exp_wd_cnt[3] = '{0, 5, 4};
    int exp_wd_tc[3]  = '{0, 1, 0};
    int exp_os_cnt[4] = '{1, 2, 3, 4};
    int exp_os_tc[4]  = '{0, 0, 0, 1};

    initial begin
        reset_n  = 1'b0;
        clr      = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        en       = 1'b0;
        up_down  = 1'b1;
        step     = 4'd3;
        limit    = 8'd9;
        mode     = 2'b00;
        start    = 1'b0;

        // Reset values
        #12;
        check("rst_count",  32'(count), 0);
        check("rst_tc",     32'(tc), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_at_min", 32'(at_min), 1);
        check("rst_at_max", 32'(at_max), 0);
        reset_n = 1'b1;
        tick();

        // Wrap up, limit 9, step 3
        load(8'd0);
        check("wu_load", 32'(count), 0);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wu_count", 32'(count), 32'(exp_wu_cnt[i]));
            check("wu_tc",    32'(tc), 32'(exp_wu_tc[i]));
            if (i == 2) check("wu_at_max", 32'(at_max), 1);
        end

        // Wrap down, step 0 acts as 1
        limit   = 8'd5;
        step    = 4'd0;
        up_down = 1'b0;
        load(8'd1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wd_count", 32'(count), 32'(exp_wd_cnt[i]));
            check("wd_tc",    32'(tc), 32'(exp_wd_tc[i]));
        end

        // Step larger than the range folds modulo limit+1
        limit   = 8'd2;
        step    = 4'd7;
        up_down = 1'b1;
        load(8'd1);
        en = 1'b1;
        tick();
        check("big_up_count", 32'(count), 2);
        check("big_up_tc",    32'(tc), 1);
        up_down = 1'b0;
        tick();
        check("big_dn_count", 32'(count), 1);
        check("big_dn_tc",    32'(tc), 1);

        // Limit lowered below count: next up step overflows
        limit   = 8'd9;
        step    = 4'd1;
        up_down = 1'b1;
        load(8'd8);
        limit = 8'd5;
        en    = 1'b1;
        tick();
        check("lim_chg_count", 32'(count), 3);
        check("lim_chg_tc",    32'(tc), 1);

        // limit 0: load clamps, every step raises tc
        limit = 8'd0;
        load(8'd5);
        check("lim0_load",   32'(count), 0);
        check("lim0_at_max", 32'(at_max), 1);
        check("lim0_tc_ld",  32'(tc), 0);
        en = 1'b1;
        tick();
        check("lim0_up_count", 32'(count), 0);
        check("lim0_up_tc",    32'(tc), 1);
        up_down = 1'b0;
        tick();
        check("lim0_dn_count", 32'(count), 0);
        check("lim0_dn_tc",    32'(tc), 1);

        // Saturate
        mode    = 2'b01;
        limit   = 8'd200;
        step    = 4'd15;
        up_down = 1'b1;
        load(8'd190);
        en = 1'b1;
        tick();
        check("sat_count1", 32'(count), 200);
        check("sat_tc1",    32'(tc), 1);
        tick();
        check("sat_count2", 32'(count), 200);
        check("sat_tc2",    32'(tc), 1);
        check("sat_at_max", 32'(at_max), 1);
        up_down = 1'b0;
        tick();
        check("sat_dn_count", 32'(count), 185);
        check("sat_dn_tc",    32'(tc), 0);

        // Priority: clr wins over load and en, then load clamps
        mode     = 2'b00;
        clr      = 1'b1;
        load_en  = 1'b1;
        load_val = 8'd7;
        en       = 1'b1;
        tick();
        check("pri_clr_count", 32'(count), 0);
        check("pri_clr_tc",    32'(tc), 0);
        clr      = 1'b0;
        en       = 1'b0;
        load_val = 8'd250;
        limit    = 8'd100;
        tick();
        load_en = 1'b0;
        check("pri_ld_count",  32'(count), 100);
        check("pri_ld_at_max", 32'(at_max), 1);

        // One-shot run
        mode    = 2'b10;
        limit   = 8'd4;
        step    = 4'd1;
        up_down = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("os_start_count", 32'(count), 0);
        check("os_start_busy",  32'(busy), 1);
        check("os_start_tc",    32'(tc), 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("os_count", 32'(count), 32'(exp_os_cnt[i]));
            check("os_tc",    32'(tc), 32'(exp_os_tc[i]));
        end
        check("os_end_busy", 32'(busy), 0);
        check("os_end_done", 32'(done), 1);
        tick();
        check("os_hold_count", 32'(count), 4);
        check("os_hold_tc",    32'(tc), 0);
        check("os_hold_done",  32'(done), 1);
        start = 1'b1;
        en    = 1'b0;
        tick();
        start = 1'b0;
        check("os_restart_count", 32'(count), 0);
        check("os_restart_busy",  32'(busy), 1);
        check("os_restart_done",  32'(done), 0);
        en = 1'b1;
        tick();
        tick();
        check("os_rerun_count", 32'(count), 2);

        // Async reset between edges while running
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_busy",  32'(busy), 0);
        check("ar_done",  32'(done), 0);
        #2;
        reset_n = 1'b1;
        tick();
        check("ar_idle_count", 32'(count), 0);
        check("ar_idle_busy",  32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ar_run_count", 32'(count), 1);
        check("ar_run_busy",  32'(busy), 1);

        // Leaving one-shot mode drops to idle
        mode = 2'b00;
        en   = 1'b0;
        tick();
        check("exit_busy", 32'(busy), 0);
        check("exit_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
